// File: rtl/echo_pkg.sv
// Shared echo definitions used by the echo TX and RX paths: sync word, length width,
// RX state encoding, FIFO word layout and the header validity check.
package echo_pkg;

   localparam logic [15:0] ECHO_SYNC_WORD = 16'hEB90;
   localparam int          ECHO_LEN_W     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } echo_rx_state_t;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } echo_fifo_word_t;

   // Header: sync in [63:48], payload length in [15:0]; a zero length is never legal.
   function automatic logic echo_hdr_ok(input logic [63:0]           word,
                                        input logic [15:0]           sync,
                                        input logic [ECHO_LEN_W-1:0] max_len);
      return (word[63:48] == sync) &&
             (word[ECHO_LEN_W-1:0] != '0) &&
             (word[ECHO_LEN_W-1:0] <= max_len);
   endfunction

endpackage

// File: rtl/echo_rx_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the head entry while not empty.
// A write while full succeeds when a read retires the head in the same cycle.
module echo_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_rd;
   logic             do_wr;

   // Extra pointer bit tells a full ring from an empty one.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/echo_rx_ctrl.sv
// Echo receive controller: registers SRIO words, validates and strips headers, buffers payload.
// Build with ECHO_RX_CRC_EN defined to expect and check a trailing XOR checksum word per frame.
module echo_rx_ctrl
   import echo_pkg::*;
#(
   parameter int          FIFO_DEPTH = 16,
   parameter int          MAX_LEN    = 256,
   parameter logic [15:0] SYNC_WORD  = ECHO_SYNC_WORD
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [63:0] srio_rx_data,
   input  logic        srio_rx_en,
   output logic [63:0] echo_rx_data,
   output logic        echo_rx_en,
   output logic        echo_rx_last,
   input  logic        echo_rx_rdy,
   output logic        hdr_err,
   output logic        ovf_flag,
   input  logic        ovf_clr,
   output logic [15:0] frame_cnt,
   output logic        crc_err
);

   localparam logic [1:0]            ST_IDLE    = IDLE;
   localparam logic [1:0]            ST_PAYLOAD = PAYLOAD;
`ifdef ECHO_RX_CRC_EN
   localparam logic [1:0]            ST_CHECK   = CHECK;
`endif
   localparam logic [ECHO_LEN_W-1:0] MAX_LEN_W  = ECHO_LEN_W'(MAX_LEN);

   logic [63:0]           data_r0;
   logic                  en_r0;
   logic [1:0]            state;
   logic [ECHO_LEN_W-1:0] len_q;
   logic [ECHO_LEN_W-1:0] idx_q;

   logic                  hdr_ok;
   logic                  wr_last;
   logic                  wr_req;
   logic                  rd_fire;
   logic                  drop;
   logic                  fifo_full;
   logic                  fifo_empty;
   echo_fifo_word_t       wr_word;
   logic [$bits(echo_fifo_word_t)-1:0] rd_raw;
   echo_fifo_word_t       head;

   assign hdr_ok  = echo_hdr_ok(data_r0, SYNC_WORD, MAX_LEN_W);
   assign wr_last = (idx_q == len_q - 1'b1);
   assign wr_req  = en_r0 && (state == ST_PAYLOAD);
   assign wr_word = '{last: wr_last, data: data_r0};
   assign rd_fire = echo_rx_en && echo_rx_rdy;
   // A full FIFO still accepts the word if the consumer frees a slot this cycle.
   assign drop    = wr_req && fifo_full && !rd_fire;

   echo_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(echo_fifo_word_t))
   ) u_fifo (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .wr_en   (wr_req),
      .wr_data (wr_word),
      .full    (fifo_full),
      .rd_en   (rd_fire),
      .rd_data (rd_raw),
      .empty   (fifo_empty)
   );

   // Stale RAM contents must not leak out while the FIFO is empty (e.g. right after reset).
   assign head         = echo_fifo_word_t'(rd_raw);
   assign echo_rx_en   = !fifo_empty;
   assign echo_rx_data = fifo_empty ? 64'd0 : head.data;
   assign echo_rx_last = !fifo_empty && head.last;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         data_r0   <= '0;
         en_r0     <= 1'b0;
         state     <= ST_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         hdr_err   <= 1'b0;
         ovf_flag  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         data_r0 <= srio_rx_data;
         en_r0   <= srio_rx_en;
         hdr_err <= 1'b0;

         if (drop)         ovf_flag <= 1'b1;
         else if (ovf_clr) ovf_flag <= 1'b0;

         if (en_r0) begin
            case (state)
               ST_IDLE: begin
                  if (hdr_ok) begin
                     len_q <= data_r0[ECHO_LEN_W-1:0];
                     idx_q <= '0;
                     state <= ST_PAYLOAD;
                  end else begin
                     hdr_err <= 1'b1;
                  end
               end
               ST_PAYLOAD: begin
                  // Index advances even for dropped words so frame boundaries stay aligned.
                  idx_q <= idx_q + 1'b1;
                  if (wr_last) begin
`ifdef ECHO_RX_CRC_EN
                     state <= ST_CHECK;
`else
                     frame_cnt <= frame_cnt + 1'b1;
                     state     <= ST_IDLE;
`endif
                  end
               end
`ifdef ECHO_RX_CRC_EN
               ST_CHECK: begin
                  frame_cnt <= frame_cnt + 1'b1;
                  state     <= ST_IDLE;
               end
`endif
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef ECHO_RX_CRC_EN
   logic [63:0] crc_acc;
   logic        crc_err_q;

   // Running XOR covers every payload word, including ones dropped on overflow.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         crc_acc   <= '0;
         crc_err_q <= 1'b0;
      end else begin
         crc_err_q <= 1'b0;
         if (en_r0) begin
            if (state == ST_IDLE)         crc_acc   <= '0;
            else if (state == ST_PAYLOAD) crc_acc   <= crc_acc ^ data_r0;
            else if (state == ST_CHECK)   crc_err_q <= (crc_acc != data_r0);
         end
      end
   end

   assign crc_err = crc_err_q;
`else
   assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_echo_rx_ctrl.sv
// Self-checking bench for echo_rx_ctrl: directed steps feed an expected-output queue that a
// negedge monitor drains on every consumer transfer.
`timescale 1ns/1ps
module tb_echo_rx_ctrl;

   localparam int FIFO_DEPTH = 16;
   localparam int MAX_LEN    = 256;

   logic        sys_clk      = 1'b0;
   logic        sys_rst      = 1'b1;
   logic [63:0] srio_rx_data = '0;
   logic        srio_rx_en   = 1'b0;
   logic        echo_rx_rdy  = 1'b0;
   logic        ovf_clr      = 1'b0;
   logic [63:0] echo_rx_data;
   logic        echo_rx_en;
   logic        echo_rx_last;
   logic        hdr_err;
   logic        ovf_flag;
   logic [15:0] frame_cnt;
   logic        crc_err;

   echo_rx_ctrl #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .MAX_LEN    (MAX_LEN),
      .SYNC_WORD  (16'hEB90)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .srio_rx_data (srio_rx_data),
      .srio_rx_en   (srio_rx_en),
      .echo_rx_data (echo_rx_data),
      .echo_rx_en   (echo_rx_en),
      .echo_rx_last (echo_rx_last),
      .echo_rx_rdy  (echo_rx_rdy),
      .hdr_err      (hdr_err),
      .ovf_flag     (ovf_flag),
      .ovf_clr      (ovf_clr),
      .frame_cnt    (frame_cnt),
      .crc_err      (crc_err)
   );

   // clock / reset
   always #5 sys_clk = ~sys_clk;

   int          checks     = 0;
   int          errors     = 0;
   int          hdr_pulses = 0;
   int          crc_pulses = 0;
   int          rdy_mode   = 0;
   int          exp_fc     = 0;
   int          hp0;
   int          cp0;
   logic [64:0] exp_q[$];
   logic [63:0] pay[MAX_LEN];

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor: a transfer happens at the next posedge when en & rdy
   always @(negedge sys_clk) begin
      if (hdr_err === 1'b1) hdr_pulses++;
      if (crc_err === 1'b1) crc_pulses++;
      if (!sys_rst && echo_rx_en === 1'b1 && echo_rx_rdy === 1'b1) begin
         check("out_expected", 65'(exp_q.size() != 0), 65'd1);
         if (exp_q.size() != 0) check("out_word", {echo_rx_last, echo_rx_data}, exp_q.pop_front());
      end
   end

   // consumer ready: 0 = stalled, 1 = always ready, 2 = random 75%
   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         case (rdy_mode)
            0:       echo_rx_rdy = 1'b0;
            1:       echo_rx_rdy = 1'b1;
            default: echo_rx_rdy = ($urandom_range(0, 99) < 75);
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // driver tasks
   function automatic logic [63:0] hdr(input logic [15:0] sync, input logic [15:0] len);
      return {sync, 32'h0, len};
   endfunction

   task automatic put(input logic [63:0] d);
      srio_rx_data = d;
      srio_rx_en   = 1'b1;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      srio_rx_en = 1'b0;
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Sends header + pay[0..len-1] (+ checksum when built with CRC); the first nstore words are expected out.
   task automatic send_frame(input int len, input int gap, input int nstore, input logic bad_crc);
      logic [63:0] x;
      x = '0;
      put(hdr(16'hEB90, 16'(len)));
      for (int i = 0; i < len; i++) begin
         while ($urandom_range(0, 99) < gap) idle(1);
         if (i < nstore) exp_q.push_back({(i == len - 1), pay[i]});
         x ^= pay[i];
         put(pay[i]);
      end
`ifdef ECHO_RX_CRC_EN
      while ($urandom_range(0, 99) < gap) idle(1);
      put(x ^ {63'd0, bad_crc});
`else
      if (bad_crc) x = ~x;
`endif
      srio_rx_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      check("drain", 65'(exp_q.size()), 65'd0);
   endtask

   initial begin
      // reset state (asynchronous, before any clock edge)
      #2;
      check("rst_en",   65'(echo_rx_en),   65'd0);
      check("rst_last", 65'(echo_rx_last), 65'd0);
      check("rst_data", 65'(echo_rx_data), 65'd0);
      check("rst_hdr",  65'(hdr_err),      65'd0);
      check("rst_ovf",  65'(ovf_flag),     65'd0);
      check("rst_fc",   65'(frame_cnt),    65'd0);
      check("rst_crc",  65'(crc_err),      65'd0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;

      // basic frame and input-to-output latency
      rdy_mode = 1;
      idle(3);
      put(hdr(16'hEB90, 16'd3));
      exp_q.push_back({1'b0, 64'h11});
      exp_q.push_back({1'b0, 64'h22});
      exp_q.push_back({1'b1, 64'h33});
      put(64'h11);
      check("lat_not_yet", 65'(echo_rx_en), 65'd0);
      put(64'h22);
      check("lat_t2_en",   65'(echo_rx_en), 65'd1);
      check("lat_t2_data", 65'(echo_rx_data), 65'h11);
      put(64'h33);
`ifdef ECHO_RX_CRC_EN
      put(64'h11 ^ 64'h22 ^ 64'h33);
`endif
      idle(3);
      wait_drain(50);
      exp_fc++;
      check("basic_fc",  65'(frame_cnt), 65'(exp_fc));
      check("basic_hdr", 65'(hdr_pulses), 65'd0);

      // bad headers: sync, zero length, length above MAX_LEN
      hp0 = hdr_pulses;
      put(hdr(16'hEB91, 16'd3));
      idle(2);
      put(hdr(16'hEB90, 16'd0));
      idle(2);
      put(hdr(16'hEB90, 16'(MAX_LEN + 1)));
      idle(3);
      check("badhdr_pulses", 65'(hdr_pulses), 65'(hp0 + 3));
      check("badhdr_empty",  65'(echo_rx_en), 65'd0);
      check("badhdr_fc",     65'(frame_cnt),  65'(exp_fc));

      // overflow: 20-word frame into a stalled 16-deep FIFO
      rdy_mode = 0;
      idle(3);
      for (int i = 0; i < 20; i++) pay[i] = {32'hA5A5_0000, 32'(i)};
      send_frame(20, 0, FIFO_DEPTH, 1'b0);
      idle(3);
      exp_fc++;
      check("ovf_set",      65'(ovf_flag),   65'd1);
      check("ovf_fc",       65'(frame_cnt),  65'(exp_fc));
      check("ovf_stall_en", 65'(echo_rx_en), 65'd1);
      check("ovf_head",     {echo_rx_last, echo_rx_data}, {1'b0, pay[0]});
      rdy_mode = 1;
      wait_drain(100);
      idle(2);
      check("ovf_drained", 65'(echo_rx_en), 65'd0);
      check("ovf_sticky",  65'(ovf_flag),   65'd1);
      ovf_clr = 1'b1;
      @(posedge sys_clk);
      #1;
      ovf_clr = 1'b0;
      check("ovf_clr", 65'(ovf_flag), 65'd0);

      // random gaps and ready over 50 frames, boundary lengths first
      rdy_mode = 2;
      for (int f = 0; f < 50; f++) begin
         int len;
         len = (f == 0) ? 1 : (f == 1) ? MAX_LEN : $urandom_range(1, MAX_LEN);
         for (int i = 0; i < len; i++) pay[i] = {$urandom, $urandom};
         send_frame(len, 60, len, 1'b0);
         idle($urandom_range(0, 2));
      end
      idle(3);
      rdy_mode = 1;
      wait_drain(2000);
      exp_fc += 50;
      check("rand_fc",  65'(frame_cnt), 65'(exp_fc));
      check("rand_ovf", 65'(ovf_flag),  65'd0);
      check("rand_hdr", 65'(hdr_pulses), 65'(hp0 + 3));

      // reset in the middle of a 5-word frame
      rdy_mode = 0;
      idle(3);
      hp0 = hdr_pulses;
      put(hdr(16'hEB90, 16'd5));
      put(64'hDEAD_0001);
      put(64'hDEAD_0002);
      idle(2);
      check("midrst_pre_en", 65'(echo_rx_en), 65'd1);
      #2;
      sys_rst = 1'b1;
      #1;
      check("midrst_en",   65'(echo_rx_en),   65'd0);
      check("midrst_data", 65'(echo_rx_data), 65'd0);
      check("midrst_last", 65'(echo_rx_last), 65'd0);
      check("midrst_fc",   65'(frame_cnt),    65'd0);
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      exp_fc = 0;
      rdy_mode = 1;
      idle(2);
      pay[0] = 64'h0123_4567_89AB_CDEF;
      pay[1] = 64'hFEDC_BA98_7654_3210;
      send_frame(2, 0, 2, 1'b0);
      idle(3);
      wait_drain(50);
      exp_fc++;
      check("midrst_next_fc", 65'(frame_cnt),  65'(exp_fc));
      check("midrst_no_hdr",  65'(hdr_pulses), 65'(hp0));

`ifdef ECHO_RX_CRC_EN
      // checksum good then bad
      cp0 = crc_pulses;
      pay[0] = 64'h0F;
      pay[1] = 64'hF0;
      send_frame(2, 0, 2, 1'b0);
      idle(3);
      check("crc_good", 65'(crc_pulses), 65'(cp0));
      send_frame(2, 0, 2, 1'b1);
      idle(3);
      check("crc_bad", 65'(crc_pulses), 65'(cp0 + 1));
      wait_drain(50);
      exp_fc += 2;
      check("crc_fc", 65'(frame_cnt), 65'(exp_fc));
`else
      cp0 = 0;
      check("crc_tied_low", 65'(crc_pulses), 65'(cp0));
`endif

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
